// File: rtl/run_step_if.sv
// Run/step sequencer panel bus: switches, buttons and feedback in; gate pulses and status out.
interface run_step_if #(
   parameter int unsigned CNT_W = 16
);
   logic [1:0]       sw_mode;
   logic             sw_step;
   logic [7:0]       step_len;
   logic             btn_start_n;
   logic             btn_stop_n;
   logic             halt;
   logic             clk_run_fb;
   logic [1:0]       cpustate;
   logic             start_n;
   logic             stop_n;
   logic             busy;
   logic             mode_err;
   logic [CNT_W-1:0] cyc_cnt;

   // Panel/CPU side drives switches and raw inputs.
   modport master (
      output sw_mode, sw_step, step_len, btn_start_n, btn_stop_n, halt, clk_run_fb,
      input  cpustate, start_n, stop_n, busy, mode_err, cyc_cnt
   );

   // Sequencer side.
   modport slave (
      input  sw_mode, sw_step, step_len, btn_start_n, btn_stop_n, halt, clk_run_fb,
      output cpustate, start_n, stop_n, busy, mode_err, cyc_cnt
   );
endinterface

// File: rtl/run_step_ctrl.sv
// Run/step sequencer for the start/stop clock gate: debounces the panel buttons,
// latches the CPU mode, emits start/stop gate pulses and counts gated clock edges.
module run_step_ctrl #(
   parameter int unsigned DEB_CYC = 16,
   parameter int unsigned PULSE_W = 4,
   parameter int unsigned CNT_W   = 16
) (
   input logic       clk_delay,
   input logic       reset,
   run_step_if.slave bus
);
   localparam int unsigned DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam int unsigned PW_W  = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
   localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PULSE_W - 1);
   localparam logic [1:0]       MODE_RUN = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_RUN   = 3'd2,
      ST_STEP  = 3'd3,
      ST_STOP  = 3'd4
   } state_t;

   // Button bit 0 = START, bit 1 = STOP.
   logic [1:0]       btn_s1, btn_s2, btn_last, btn_lvl, btn_ev;
   logic [DEB_W-1:0] deb_cnt [2];
   logic             halt_s1, halt_s2, halt_prev;
   logic             fb_s1, fb_s2, fb_prev;
   logic             start_ev, stop_ev, halt_ev, fb_edge;

   state_t           state_q, state_d;
   logic [PW_W-1:0]  pcnt_q, pcnt_d;
   logic [7:0]       step_rem_q, step_rem_d;
   logic             step_cap_q, step_cap_d;
   logic             stop_pend_q, stop_pend_d;
   logic [1:0]       cpustate_q, cpustate_d;
   logic             start_n_q, start_n_d;
   logic             stop_n_q, stop_n_d;
   logic             busy_q, busy_d;
   logic             mode_err_q, mode_err_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic             enter_start;

   // Two-flop synchronisers for all asynchronous inputs.
   always_ff @(posedge clk_delay or negedge reset) begin
      if (!reset) begin
         btn_s1    <= '1;
         btn_s2    <= '1;
         halt_s1   <= 1'b0;
         halt_s2   <= 1'b0;
         halt_prev <= 1'b0;
         fb_s1     <= 1'b0;
         fb_s2     <= 1'b0;
         fb_prev   <= 1'b0;
      end else begin
         btn_s1    <= {bus.btn_stop_n, bus.btn_start_n};
         btn_s2    <= btn_s1;
         halt_s1   <= bus.halt;
         halt_s2   <= halt_s1;
         halt_prev <= halt_s2;
         fb_s1     <= bus.clk_run_fb;
         fb_s2     <= fb_s1;
         fb_prev   <= fb_s2;
      end
   end

   // Debounce: accept a level after DEB_CYC stable samples; flag accepted presses.
   always_ff @(posedge clk_delay or negedge reset) begin
      if (!reset) begin
         btn_last <= '1;
         btn_lvl  <= '1;
         btn_ev   <= '0;
         for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
      end else begin
         btn_last <= btn_s2;
         for (int i = 0; i < 2; i++) begin
            if (btn_s2[i] != btn_last[i])
               deb_cnt[i] <= '0;
            else if (deb_cnt[i] != DEB_LAST)
               deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            btn_ev[i] <= (btn_s2[i] == btn_last[i]) && (deb_cnt[i] == DEB_LAST) &&
                         btn_lvl[i] && !btn_s2[i];
            if ((btn_s2[i] == btn_last[i]) && (deb_cnt[i] == DEB_LAST))
               btn_lvl[i] <= btn_s2[i];
         end
      end
   end

   assign start_ev = btn_ev[0];
   assign stop_ev  = btn_ev[1];
   assign halt_ev  = halt_s2 & ~halt_prev;
   assign fb_edge  = fb_s2 & ~fb_prev;

   // State register.
   always_ff @(posedge clk_delay or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; a simultaneous STOP always beats START.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!stop_ev && start_ev && (cpustate_q == MODE_RUN)) state_d = ST_START;
         end
         ST_START: begin
            if (pcnt_q == PW_LAST) begin
               if (stop_pend_q || stop_ev || halt_ev) state_d = ST_STOP;
               else if (step_cap_q)                   state_d = ST_STEP;
               else                                   state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop_ev || halt_ev) state_d = ST_STOP;
         end
         ST_STEP: begin
            if (stop_ev || halt_ev)                     state_d = ST_STOP;
            else if (fb_edge && (step_rem_q == 8'd1))   state_d = ST_STOP;
         end
         ST_STOP: begin
            if (pcnt_q == PW_LAST) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values; pulses are decoded from the next state.
   always_comb begin
      enter_start = (state_q == ST_IDLE) && (state_d == ST_START);
      start_n_d   = (state_d != ST_START);
      stop_n_d    = (state_d != ST_STOP);
      busy_d      = (state_d != ST_IDLE);
      mode_err_d  = (state_q == ST_IDLE) && start_ev && !stop_ev && (cpustate_q != MODE_RUN);
      cpustate_d  = (state_q == ST_IDLE) ? bus.sw_mode : cpustate_q;
      step_cap_d  = enter_start ? bus.sw_step : step_cap_q;
      stop_pend_d = (state_q == ST_START) ? (stop_pend_q | stop_ev | halt_ev) : 1'b0;

      pcnt_d = '0;
      if ((state_d == state_q) && ((state_q == ST_START) || (state_q == ST_STOP)))
         pcnt_d = pcnt_q + PW_W'(1);

      step_rem_d = step_rem_q;
      if (enter_start)
         step_rem_d = (bus.step_len == 8'd0) ? 8'd1 : bus.step_len;
      else if ((state_q == ST_STEP) && fb_edge && (step_rem_q != 8'd0))
         step_rem_d = step_rem_q - 8'd1;

      cyc_d = cyc_q;
      if (enter_start)
         cyc_d = '0;
      else if (fb_edge && (state_q != ST_IDLE) && (cyc_q != {CNT_W{1'b1}}))
         cyc_d = cyc_q + CNT_W'(1);
   end

   // Registered outputs and burst bookkeeping.
   always_ff @(posedge clk_delay or negedge reset) begin
      if (!reset) begin
         pcnt_q      <= '0;
         step_rem_q  <= 8'd0;
         step_cap_q  <= 1'b0;
         stop_pend_q <= 1'b0;
         cpustate_q  <= 2'b00;
         start_n_q   <= 1'b1;
         stop_n_q    <= 1'b1;
         busy_q      <= 1'b0;
         mode_err_q  <= 1'b0;
         cyc_q       <= '0;
      end else begin
         pcnt_q      <= pcnt_d;
         step_rem_q  <= step_rem_d;
         step_cap_q  <= step_cap_d;
         stop_pend_q <= stop_pend_d;
         cpustate_q  <= cpustate_d;
         start_n_q   <= start_n_d;
         stop_n_q    <= stop_n_d;
         busy_q      <= busy_d;
         mode_err_q  <= mode_err_d;
         cyc_q       <= cyc_d;
      end
   end

   assign bus.cpustate = cpustate_q;
   assign bus.start_n  = start_n_q;
   assign bus.stop_n   = stop_n_q;
   assign bus.busy     = busy_q;
   assign bus.mode_err = mode_err_q;
   assign bus.cyc_cnt  = cyc_q;

endmodule

// File: tb/tb_run_step_ctrl.sv
// Bench for run_step_ctrl: table of start requests scored through a queue,
// plus hand sequences for glitch, mode freeze, halt, simultaneous buttons,
// saturation and reset mid-burst.
module tb_run_step_ctrl;
   localparam int unsigned DEB = 16;
   localparam int unsigned PW  = 4;

   logic clk_delay = 1'b0;
   logic reset     = 1'b1;
   always #5 clk_delay = ~clk_delay;

   run_step_if #(.CNT_W(16)) bus ();
   run_step_if #(.CNT_W(4))  bus4 ();

   run_step_ctrl #(.DEB_CYC(DEB), .PULSE_W(PW), .CNT_W(16)) dut (
      .clk_delay (clk_delay),
      .reset     (reset),
      .bus       (bus)
   );

   run_step_ctrl #(.DEB_CYC(DEB), .PULSE_W(PW), .CNT_W(4)) dut4 (
      .clk_delay (clk_delay),
      .reset     (reset),
      .bus       (bus4)
   );

   assign bus4.sw_mode     = bus.sw_mode;
   assign bus4.sw_step     = bus.sw_step;
   assign bus4.step_len    = bus.step_len;
   assign bus4.btn_start_n = bus.btn_start_n;
   assign bus4.btn_stop_n  = bus.btn_stop_n;
   assign bus4.halt        = bus.halt;
   assign bus4.clk_run_fb  = bus.clk_run_fb;

   typedef struct {
      logic [1:0] mode;
      logic       step;
      logic [7:0] len;
      int         run_edges;
      int         exp_cyc;
   } vec_t;

   typedef struct {
      int         start_p;
      int         stop_p;
      int         me;
      int         cyc;
      logic [1:0] cps;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   int   n_start = 0, n_stop = 0, n_me = 0;
   int   w_start = 0, w_stop = 0, w_me = 0;
   exp_t sbq[$];

   task automatic chk(input string nm, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_delay);
   endtask

   // Pulse monitor: width of every start/stop/mode_err pulse and mutual exclusion.
   always @(negedge clk_delay) begin
      if (!reset) begin
         w_start = 0; w_stop = 0; w_me = 0;
      end else begin
         if (!bus.start_n || !bus.stop_n)
            chk("pulse_excl", longint'(bus.start_n) + longint'(bus.stop_n), 1);
         if (!bus.start_n) w_start++;
         else if (w_start != 0) begin chk("start_n_width", w_start, PW); n_start++; w_start = 0; end
         if (!bus.stop_n) w_stop++;
         else if (w_stop != 0) begin chk("stop_n_width", w_stop, PW); n_stop++; w_stop = 0; end
         if (bus.mode_err) w_me++;
         else if (w_me != 0) begin chk("mode_err_width", w_me, 1); n_me++; w_me = 0; end
      end
   end

   task automatic press_start(output bit got_start, output bit got_me);
      got_start = 1'b0;
      got_me    = 1'b0;
      bus.btn_start_n = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_delay);
         if (!bus.start_n) begin got_start = 1'b1; break; end
         if (bus.mode_err) begin got_me = 1'b1; break; end
      end
      chk("start_resp", longint'(got_start | got_me), 1);
      bus.btn_start_n = 1'b1;
      cyc(DEB + 6);
   endtask

   task automatic press_stop();
      bit got = 1'b0;
      bus.btn_stop_n = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_delay);
         if (!bus.stop_n) begin got = 1'b1; break; end
      end
      chk("stop_resp", longint'(got), 1);
      bus.btn_stop_n = 1'b1;
      cyc(DEB + 6);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (!bus.busy) begin ok = 1'b1; break; end
         @(negedge clk_delay);
      end
      chk("idle_resp", longint'(ok), 1);
   endtask

   task automatic gen_edges(input int k);
      for (int i = 0; i < k; i++) begin
         bus.clk_run_fb = 1'b1; cyc(4);
         bus.clk_run_fb = 1'b0; cyc(4);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      exp_t e;
      bit   gs, gm, found, busy_seen;
      int   sp, ep, mp, eff;

      vecs[0] = '{2'b11, 1'b0, 8'd0,   5, 5};
      vecs[1] = '{2'b01, 1'b0, 8'd0,   0, 5};
      vecs[2] = '{2'b11, 1'b1, 8'd3,   0, 3};
      vecs[3] = '{2'b11, 1'b1, 8'd0,   0, 1};
      vecs[4] = '{2'b10, 1'b1, 8'd9,   0, 1};
      vecs[5] = '{2'b11, 1'b1, 8'd7,   0, 7};
      vecs[6] = '{2'b11, 1'b0, 8'd200, 2, 2};
      vecs[7] = '{2'b00, 1'b0, 8'd0,   0, 2};

      bus.sw_mode = 2'b11; bus.sw_step = 1'b0; bus.step_len = 8'd1;
      bus.btn_start_n = 1'b1; bus.btn_stop_n = 1'b1;
      bus.halt = 1'b0; bus.clk_run_fb = 1'b0;

      // Reset values.
      #2 reset = 1'b0;
      #1;
      chk("rst_start_n",  bus.start_n,  1);
      chk("rst_stop_n",   bus.stop_n,   1);
      chk("rst_busy",     bus.busy,     0);
      chk("rst_mode_err", bus.mode_err, 0);
      chk("rst_cpustate", bus.cpustate, 0);
      chk("rst_cyc_cnt",  bus.cyc_cnt,  0);
      cyc(3);
      reset = 1'b1;
      cyc(4);

      // Table: each start request pushes its expectation, popped once the burst ends.
      for (int v = 0; v < 8; v++) begin
         bus.sw_mode = vecs[v].mode; bus.sw_step = vecs[v].step; bus.step_len = vecs[v].len;
         cyc(3);
         sp = n_start; ep = n_stop; mp = n_me;
         e.start_p = (vecs[v].mode == 2'b11) ? 1 : 0;
         e.stop_p  = e.start_p;
         e.me      = 1 - e.start_p;
         e.cyc     = vecs[v].exp_cyc;
         e.cps     = vecs[v].mode;
         sbq.push_back(e);
         press_start(gs, gm);
         if (gs) begin
            if (vecs[v].step) begin
               eff = (vecs[v].len == 8'd0) ? 1 : int'(vecs[v].len);
               gen_edges(eff);
            end else begin
               gen_edges(vecs[v].run_edges);
               press_stop();
            end
         end
         wait_idle();
         cyc(2);
         e = sbq.pop_front();
         chk($sformatf("v%0d_start_pulses", v), n_start - sp, e.start_p);
         chk($sformatf("v%0d_stop_pulses", v),  n_stop - ep,  e.stop_p);
         chk($sformatf("v%0d_mode_err", v),     n_me - mp,    e.me);
         chk($sformatf("v%0d_cyc_cnt", v),      bus.cyc_cnt,  e.cyc);
         chk($sformatf("v%0d_cpustate", v),     bus.cpustate, e.cps);
      end

      // Short glitch on START must be rejected.
      bus.sw_mode = 2'b11; bus.sw_step = 1'b0;
      cyc(3);
      sp = n_start;
      bus.btn_start_n = 1'b0; cyc(5); bus.btn_start_n = 1'b1;
      cyc(40);
      chk("glitch_start_pulses", n_start - sp, 0);
      chk("glitch_busy", bus.busy, 0);

      // Mode switch changes are ignored until the sequencer is back in IDLE.
      press_start(gs, gm);
      bus.sw_mode = 2'b01;
      cyc(5);
      chk("run_cpustate_frozen", bus.cpustate, 3);
      chk("run_busy", bus.busy, 1);
      press_stop();
      wait_idle();
      cyc(2);
      chk("idle_cpustate_reload", bus.cpustate, 1);

      // HALT in RUN stops within a few cycles of the raw edge.
      bus.sw_mode = 2'b11;
      cyc(3);
      press_start(gs, gm);
      ep = n_stop;
      bus.halt = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_delay);
         if (!bus.stop_n) begin found = 1'b1; break; end
      end
      chk("halt_stop_low", longint'(found), 1);
      wait_idle();
      cyc(2);
      chk("halt_stop_pulses", n_stop - ep, 1);
      bus.halt = 1'b0;
      cyc(4);

      // START and STOP accepted together in IDLE: STOP wins, nothing happens.
      sp = n_start; ep = n_stop; mp = n_me;
      busy_seen = 1'b0;
      bus.btn_start_n = 1'b0; bus.btn_stop_n = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_delay);
         if (bus.busy) busy_seen = 1'b1;
      end
      bus.btn_start_n = 1'b1; bus.btn_stop_n = 1'b1;
      cyc(DEB + 6);
      chk("both_start_pulses", n_start - sp, 0);
      chk("both_stop_pulses",  n_stop - ep,  0);
      chk("both_mode_err",     n_me - mp,    0);
      chk("both_busy_seen",    longint'(busy_seen), 0);

      // Counter saturation on the narrow-counter instance.
      bus.sw_step = 1'b0;
      press_start(gs, gm);
      gen_edges(20);
      chk("sat_cnt4", bus4.cyc_cnt, 15);
      chk("sat_cnt16", bus.cyc_cnt, 20);
      press_stop();
      wait_idle();

      // Reset in the middle of a step burst clears everything, no stop pulse.
      bus.sw_step = 1'b1; bus.step_len = 8'd10;
      cyc(3);
      press_start(gs, gm);
      gen_edges(2);
      chk("burst_cyc_cnt", bus.cyc_cnt, 2);
      ep = n_stop;
      reset = 1'b0;
      #1;
      chk("mid_rst_start_n",  bus.start_n,  1);
      chk("mid_rst_stop_n",   bus.stop_n,   1);
      chk("mid_rst_cpustate", bus.cpustate, 0);
      chk("mid_rst_cyc_cnt",  bus.cyc_cnt,  0);
      chk("mid_rst_busy",     bus.busy,     0);
      cyc(3);
      reset = 1'b1;
      cyc(20);
      chk("mid_rst_stop_pulses", n_stop - ep, 0);
      chk("mid_rst_busy_after", bus.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
